// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, register-select encodings and
// default widths used by the fetch/decode stage and its decoder.
package cpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    RSEL_RM   = 2'b00,
    RSEL_RD   = 2'b01,
    RSEL_RN   = 2'b10,
    RSEL_NONE = 2'b11
  } rsel_e;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder.
// Ports:
//   ir       - instruction register contents
//   reg_sel  - register-number select from the controller
//   opcode   - ir[15:13]
//   ALU_op   - ir[12:11]
//   shift_op - ir[4:3], zero for load/store
//   r_addr   - Rm/Rd/Rn selected by reg_sel, 0 for the unused encoding
//   sximm8   - ir[7:0] sign-extended
//   sximm5   - ir[4:0] sign-extended
module instr_dec
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [1:0]        reg_sel,
  output logic [2:0]        opcode,
  output logic [1:0]        ALU_op,
  output logic [1:0]        shift_op,
  output logic [2:0]        r_addr,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5
);

  assign opcode = ir[15:13];
  assign ALU_op = ir[12:11];
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

  // Load/store reuse ir[4:3] as part of the offset, so no shift is applied.
  always_comb begin
    shift_op = ir[4:3];
    if (opcode == OP_LDR || opcode == OP_STR) shift_op = 2'b00;
  end

  always_comb begin
    r_addr = 3'b000;
    case (reg_sel)
      RSEL_RM: r_addr = ir[2:0];
      RSEL_RD: r_addr = ir[7:5];
      RSEL_RN: r_addr = ir[10:8];
      default: r_addr = 3'b000;
    endcase
  end

  logic unused_ir_hi;
  if (DATA_W > 16) begin : g_hi
    assign unused_ir_hi = ^ir[DATA_W-1:16];
  end else begin : g_no_hi
    assign unused_ir_hi = 1'b0;
  end

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch and decode stage upstream of the controller FSM.
// Owns PC, data address register, RAM address mux and IR; decodes IR into
// controller/datapath fields and tracks IR validity, halt, retired count and
// PC wrap.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   clear_pc, load_pc        - PC reset-select and load enable
//   load_addr, sel_addr      - data address load, RAM address select (1 = PC)
//   load_ir, reg_sel         - IR load enable, register-number select
//   datapath_out, ram_r_data - data address source, RAM read data
//   ram_addr, pc             - RAM address, current PC
//   opcode..sximm5           - decoded IR fields
//   ir_valid, halted         - IR holds current-PC instruction, HALT seen
//   instr_count, pc_wrapped  - fetched-instruction count, sticky PC wrap
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_pc,
  input  logic              load_pc,
  input  logic              load_addr,
  input  logic              sel_addr,
  input  logic              load_ir,
  input  logic [1:0]        reg_sel,
  input  logic [DATA_W-1:0] datapath_out,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        opcode,
  output logic [1:0]        ALU_op,
  output logic [1:0]        shift_op,
  output logic [2:0]        r_addr,
  output logic [DATA_W-1:0] sximm8,
  output logic [DATA_W-1:0] sximm5,
  output logic              ir_valid,
  output logic              halted,
  output logic [15:0]       instr_count,
  output logic              pc_wrapped
);

  logic [ADDR_W-1:0] dar;
  logic [DATA_W-1:0] ir;
  logic              pc_en, ir_en, addr_en;
  logic              ir_valid_nxt;

  // A halted core freezes all architectural loads.
  assign pc_en   = load_pc   & ~halted;
  assign ir_en   = load_ir   & ~halted;
  assign addr_en = load_addr & ~halted;

  assign ram_addr = sel_addr ? pc : dar;

  // A PC change invalidates the IR; only an instruction fetch (PC-addressed
  // read) makes it valid again.
  always_comb begin
    ir_valid_nxt = ir_valid;
    if (pc_en)      ir_valid_nxt = 1'b0;
    else if (ir_en) ir_valid_nxt = sel_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      dar         <= '0;
      ir          <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
      pc_wrapped  <= 1'b0;
    end else begin
      if (pc_en) begin
        pc <= clear_pc ? RESET_PC : pc + ADDR_W'(1);
        if (!clear_pc && (&pc)) pc_wrapped <= 1'b1;
      end
      if (addr_en) dar <= datapath_out[ADDR_W-1:0];
      if (ir_en)   ir  <= ram_r_data;
      ir_valid <= ir_valid_nxt;
      if (!ir_valid && ir_valid_nxt) instr_count <= instr_count + 16'd1;
      if (ir_valid && opcode == OP_HALT) halted <= 1'b1;
    end
  end

  instr_dec #(.DATA_W(DATA_W)) u_dec (
    .ir       (ir),
    .reg_sel  (reg_sel),
    .opcode   (opcode),
    .ALU_op   (ALU_op),
    .shift_op (shift_op),
    .r_addr   (r_addr),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  logic unused_dp;
  assign unused_dp = ^datapath_out[DATA_W-1:ADDR_W];

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Instruction-fetch and decode stage that sits directly upstream of the CPU controller FSM.
- Owns the program counter, the data address register, the RAM address mux and the instruction register.
- Splits the instruction register into the opcode, ALU_op and shift_op fields the controller consumes. Also produces the register-number and sign-extended immediate fields the datapath consumes.
- Adds sequential bookkeeping: an IR-valid flag, a halt latch, a retired-instruction counter and a sticky PC-wrap flag.

Parameters:
- ADDR_W, 8, width of PC, data address register and RAM address.
- DATA_W, 16, instruction and datapath word width.
- RESET_PC, 0, PC value after reset and after a clear load.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- clear_pc  in  1  from controller; selects RESET_PC as the next PC.
- load_pc  in  1  from controller; PC load enable.
- load_addr  in  1  from controller; data address register load enable.
- sel_addr  in  1  from controller; 1 = RAM address is PC, 0 = data address register.
- load_ir  in  1  from controller; IR load enable.
- reg_sel  in  2  from controller; register-number select.
- datapath_out  in  DATA_W  datapath C output, source of the data address.
- ram_r_data  in  DATA_W  RAM read data (combinational read of ram_addr).
- ram_addr  out  ADDR_W  RAM address.
- pc  out  ADDR_W  current PC.
- opcode  out  3  IR[15:13].
- ALU_op  out  2  IR[12:11].
- shift_op  out  2  IR[4:3], forced to 00 for opcode 011 and opcode 100.
- r_addr  out  3  register number selected by reg_sel.
- sximm8  out  DATA_W  IR[7:0] sign-extended.
- sximm5  out  DATA_W  IR[4:0] sign-extended.
- ir_valid  out  1  IR holds the instruction at the current PC.
- halted  out  1  HALT (opcode 111) has been decoded.
- instr_count  out  16  number of instructions fetched.
- pc_wrapped  out  1  sticky flag: PC has wrapped from max to 0.

Behaviour:
- Reset (rst=1 at posedge, overrides everything, including mid-fetch) sets:
  - pc=RESET_PC, data address register=0, IR=0;
  - ir_valid=0, halted=0, instr_count=0, pc_wrapped=0.
  - Decoded outputs then follow IR=0: opcode=000, r_addr=IR[2:0]=0, sximm=0.
- PC:
  - Updates only when load_pc=1.
  - New value is RESET_PC if clear_pc=1, otherwise pc+1 modulo 2^ADDR_W.
  - clear_pc without load_pc has no effect.
  - An increment from all-ones to 0 sets pc_wrapped; it stays set until rst.
- Data address register: loads datapath_out[ADDR_W-1:0] when load_addr=1; upper bits are discarded.
- RAM address: ram_addr = sel_addr ? pc : data address register. Purely combinational, zero latency.
- IR:
  - Loads ram_r_data when load_ir=1, regardless of sel_addr.
  - Holding load_ir for several cycles reloads the same word.
- ir_valid:
  - Next value is 1 if load_ir=1 and sel_addr=1 and load_pc=0.
  - Next value is 0 if load_pc=1; load_pc wins when asserted simultaneously with load_ir.
  - Otherwise it holds.
  - An IR load with sel_addr=0 (data read) clears ir_valid.
- instr_count: increments by 1 on every 0->1 transition of ir_valid, wrapping at 2^16.
- halted:
  - Set on the cycle after ir_valid=1 with opcode=111.
  - While halted=1: load_pc, load_ir and load_addr are ignored, so PC, IR and the data address register freeze.
  - Cleared only by rst.
- r_addr decode:
  - reg_sel=00 -> Rm = IR[2:0];
  - reg_sel=01 -> Rd = IR[7:5];
  - reg_sel=10 -> Rn = IR[10:8];
  - reg_sel=11 -> 000.
- All decoded fields are combinational from IR. Values change in the cycle after the IR load edge.
- Latency: an instruction presented on ram_r_data with load_ir=1 and sel_addr=1 is visible on opcode/ALU_op in the next cycle, with ir_valid=1.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: OP_MOV=110, OP_ALU=101, OP_LDR=011, OP_STR=100, OP_HALT=111;
  - reg_sel encodings: RSEL_RM=00, RSEL_RD=01, RSEL_RN=10;
  - ADDR_W and DATA_W defaults.
- One natural sub-module: instr_dec. It is purely combinational: IR plus reg_sel in, opcode/ALU_op/shift_op/r_addr/sximm8/sximm5 out.
- PC, data address register, IR and the flags stay in fetch_decode.

Test Plan:
- Reset then a fetch: rst for 1 cycle, then load_pc=1 with clear_pc=1 -> pc=0. Then sel_addr=1, load_ir=1 with ram_r_data=16'hD0A5 (MOV R0,#-91) -> next cycle opcode=110, ALU_op=10, sximm8=16'hFFA5, ir_valid=1, instr_count=1.
- Increment and wrap: preload pc=8'hFF, then load_pc=1 with clear_pc=0 -> pc=0, pc_wrapped=1. A further rst clears pc_wrapped.
- Data access: datapath_out=16'h1234 with load_addr=1, then sel_addr=0 -> ram_addr=8'h34. load_ir with sel_addr=0 -> ir_valid=0.
- LDR shift forcing and register select: IR=16'h6218 (opcode 011, shift bits 11) -> shift_op=00. reg_sel=00/01/10/11 -> r_addr=0/0/2/0.
- Simultaneous load_pc and load_ir in the same cycle -> IR loaded, ir_valid=0, instr_count unchanged.
- Halt: fetch 16'hE000 -> halted=1 next cycle. Subsequent load_pc/load_ir pulses leave pc and IR unchanged; rst restores pc=0 and halted=0.
